enable_pulse_gen: RTL and testbench
===================================

Name: enable_pulse_gen

Overview:
- Upstream stage of four_bit counter logic: produces the single-cycle EN strobe that advances the counter.
- Two sources, selected by a mode switch:
  - Manual: debounced push-button, one strobe per press.
  - Auto: free-running prescaler tick.
- All inputs are asynchronous board signals. They are synchronized internally and en_pulse is a registered output.

Parameters:
- SYNC_STAGES, 2: synchronizer flip-flop depth for btn_raw and mode; must be at least 2.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a level change; must be at least 2.
- PRESCALE, 50000000: auto-mode tick period in clk cycles; must be at least 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- btn_raw  input  1  raw push-button, active-high, asynchronous, bouncy.
- mode  input  1  0 = manual (button), 1 = auto (prescaler); asynchronous slide switch.
- en_pulse  output  1  one-cycle enable strobe to the counter.
- btn_level  output  1  debounced button level.
- mode_s  output  1  synchronized mode, exported for status LED.

Behaviour:
- Reset (rst=0): all synchronizer FFs, FSM, debounce counter and prescaler go to 0. Outputs en_pulse=0, btn_level=0, mode_s=0. Reset release is not a press event.
- Synchronizers: btn_s and mode_s are the last stage of a SYNC_STAGES-deep FF chain.
- Debounce FSM states (2-bit encoding):
  - IDLE_LOW (00): btn_s=1 moves to WAIT_HIGH with dcnt=0.
  - WAIT_HIGH (01):
    - btn_s=0 returns to IDLE_LOW and clears dcnt (glitch rejected, no strobe).
    - btn_s=1 with dcnt==DEBOUNCE_CYCLES-1 moves to IDLE_HIGH and raises press.
    - Otherwise dcnt increments.
  - IDLE_HIGH (10): btn_s=0 moves to WAIT_LOW with dcnt=0.
  - WAIT_LOW (11):
    - btn_s=1 returns to IDLE_HIGH.
    - btn_s=0 with dcnt==DEBOUNCE_CYCLES-1 moves to IDLE_LOW.
    - Otherwise dcnt increments.
    - Release never produces a strobe.
- btn_level is 1 in IDLE_HIGH and WAIT_LOW, 0 otherwise.
- dcnt width is clog2(DEBOUNCE_CYCLES). It never wraps because it is cleared on every state change.
- Manual latency: if btn_raw is high before edge 0 and stays high, en_pulse=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES and 0 after the next edge. Exactly one strobe per accepted press, regardless of hold time.
- Prescaler:
  - pcnt width is clog2(PRESCALE).
  - Held at 0 while mode_s=0.
  - While mode_s=1 it increments each cycle. At pcnt==PRESCALE-1 it wraps to 0 and raises tick.
  - Strobe period is exactly PRESCALE cycles. The first strobe comes PRESCALE edges after the first edge with mode_s=1.
- Output selection: en_pulse is registered, equal to (mode_s ? tick : press).
  - The debouncer keeps running in auto mode, but its presses are discarded.
  - Prescaler ticks are never emitted in manual mode.
- Mode change while a press is pending: the strobe follows the mode_s value in force on the edge the event fires. An event is never deferred or queued.
- Mid-operation reset: clears immediately, with no strobe during or on release.
  - A button held through reset release is seen as a new press: strobe after SYNC_STAGES+DEBOUNCE_CYCLES.
  - The prescaler restarts from 0.
- en_pulse is never high on two consecutive cycles, for any parameter set meeting the minimums.

Decomposition:
- Shared package enable_pulse_pkg holds:
  - Debounce state encodings IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - A clog2 width helper function.
- One sub-module, sync_chain (parameter STAGES, 1-bit d/q, clk, rst), instantiated twice: for btn_raw and for mode.
- FSM, dcnt, prescaler and output register live in enable_pulse_gen.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PRESCALE=5):
- Clean press: mode=0, btn_raw held 1 from before edge 0 -> en_pulse=1 only in the cycle after edge 6; btn_level=1 from edge 6; no further strobe during a 50-cycle hold.
- Bounce: btn_raw toggles 1,0,1,1,0 on successive edges, then stays 1 -> FSM returns to IDLE_LOW at each drop; exactly one strobe, 6 edges after the final stable rise.
- Release: after an accepted press, btn_raw goes 0 -> btn_level falls after edge 2+4; en_pulse stays 0 throughout.
- Auto mode: mode=1, btn_raw=0 -> first strobe 5 edges after mode_s rises, then every 5 cycles; 4 strobes in 20 cycles; a button press in auto mode adds no strobe.
- Reset mid-press: rst=0 asynchronously while the FSM is in WAIT_HIGH with dcnt=2 -> all outputs 0 immediately; btn held, rst released -> one strobe 6 edges later.
- Mode switch: mode 1 to 0 with pcnt=3 -> no tick emitted after mode_s falls; pcnt reads 0; a subsequent press strobes normally.

Source files
------------

// File: rtl/enable_pulse_pkg.sv
// -----------------------------------------------------------------------------
// enable_pulse_pkg
//
// Shared definitions for the enable pulse generator:
//   - deb_state_t : debounce FSM state encodings (2-bit, fixed values so the
//                   state register can be probed on a logic analyser)
//   - clog2       : register width helper for the debounce and prescale
//                   counters
// -----------------------------------------------------------------------------
package enable_pulse_pkg;

    // Debounce FSM states. Bit 1 is the accepted (debounced) level; bit 0 is
    // set while a candidate level change is being qualified.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } deb_state_t;

    // Number of bits needed to hold the values 0 .. value-1.
    // Never returns less than 1 so that degenerate sizes still give a
    // legal vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned bits;
        v    = (value > 0) ? value - 1 : 0;
        bits = 0;
        while (v > 0) begin
            v    = v >> 1;
            bits = bits + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage : enable_pulse_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//
// Multi-flop synchronizer for a single asynchronous board signal.
//
// Parameters:
//   STAGES : number of flip-flops in the chain (at least 2)
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-low reset; clears every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule : sync_chain

// File: rtl/enable_pulse_gen.sv
// -----------------------------------------------------------------------------
// enable_pulse_gen
//
// Produces the single-cycle EN strobe that advances the downstream four-bit
// counter. Two strobe sources, selected by the synchronized mode switch:
//   manual (mode_s=0) : one strobe per debounced button press
//   auto   (mode_s=1) : one strobe every PRESCALE clock cycles
//
// Parameters:
//   SYNC_STAGES     : synchronizer depth for btn_raw and mode (>= 2)
//   DEBOUNCE_CYCLES : consecutive stable samples to accept a level change (>= 2)
//   PRESCALE        : auto-mode strobe period in clk cycles (>= 2)
//
// Ports:
//   clk       : system clock, rising-edge active
//   rst       : asynchronous, active-low reset
//   btn_raw   : raw push-button, active-high, bouncy, asynchronous
//   mode      : 0 = manual, 1 = auto; asynchronous slide switch
//   en_pulse  : registered one-cycle enable strobe
//   btn_level : debounced button level
//   mode_s    : synchronized mode, for the status LED
// -----------------------------------------------------------------------------
module enable_pulse_gen
    import enable_pulse_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PRESCALE        = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic mode,
    output logic en_pulse,
    output logic btn_level,
    output logic mode_s
);

    localparam int unsigned DCNT_W = clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PCNT_W = clog2(PRESCALE);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    logic w_btn_s;
    logic w_mode_s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (w_btn_s)
    );

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_mode (
        .clk (clk),
        .rst (rst),
        .d   (mode),
        .q   (w_mode_s)
    );

    // -------------------------------------------------------------------------
    // Debounce FSM
    // -------------------------------------------------------------------------
    deb_state_t        r_state;
    deb_state_t        w_state_nxt;
    logic [DCNT_W-1:0] r_dcnt;
    logic [DCNT_W-1:0] w_dcnt_nxt;
    logic              w_press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE_LOW;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // dcnt is cleared on every state change, so it can never wrap even
    // though it is only clog2(DEBOUNCE_CYCLES) bits wide.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_press     = 1'b0;

        unique case (r_state)
            IDLE_LOW: begin
                if (w_btn_s) begin
                    w_state_nxt = WAIT_HIGH;
                    w_dcnt_nxt  = '0;
                end
            end

            WAIT_HIGH: begin
                if (!w_btn_s) begin
                    // Glitch: fall back without a strobe.
                    w_state_nxt = IDLE_LOW;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_dcnt_nxt  = '0;
                    w_press     = 1'b1;
                end else begin
                    w_dcnt_nxt  = r_dcnt + DCNT_W'(1);
                end
            end

            IDLE_HIGH: begin
                if (!w_btn_s) begin
                    w_state_nxt = WAIT_LOW;
                    w_dcnt_nxt  = '0;
                end
            end

            WAIT_LOW: begin
                // Release is qualified the same way but never strobes.
                if (w_btn_s) begin
                    w_state_nxt = IDLE_HIGH;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt  = r_dcnt + DCNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE_LOW;
                w_dcnt_nxt  = '0;
            end
        endcase
    end

    assign btn_level = (r_state == IDLE_HIGH) || (r_state == WAIT_LOW);

    // -------------------------------------------------------------------------
    // Auto-mode prescaler
    // -------------------------------------------------------------------------
    logic [PCNT_W-1:0] r_pcnt;
    logic [PCNT_W-1:0] w_pcnt_nxt;
    logic              w_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= w_pcnt_nxt;
        end
    end

    // Held at zero in manual mode so the first auto strobe always lands
    // exactly PRESCALE edges after mode_s rises.
    always_comb begin
        w_tick     = 1'b0;
        w_pcnt_nxt = '0;
        if (w_mode_s) begin
            if (r_pcnt == PCNT_LAST) begin
                w_tick     = 1'b1;
                w_pcnt_nxt = '0;
            end else begin
                w_pcnt_nxt = r_pcnt + PCNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output strobe register
    // -------------------------------------------------------------------------
    logic r_en;
    logic w_en_nxt;

    // The source is picked by mode_s on the edge the event fires. A tick on
    // the last auto edge followed by a press on the first manual edge would
    // otherwise give two adjacent strobes, so an event directly after a strobe
    // is dropped (never deferred).
    always_comb begin
        w_en_nxt = 1'b0;
        if (!r_en) begin
            w_en_nxt = w_mode_s ? w_tick : w_press;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en <= 1'b0;
        end else begin
            r_en <= w_en_nxt;
        end
    end

    assign en_pulse = r_en;
    assign mode_s   = w_mode_s;

endmodule : enable_pulse_gen

// File: tb/tb_enable_pulse_gen.sv
module tb_enable_pulse_gen;

    localparam int unsigned S = 2;
    localparam int unsigned D = 4;
    localparam int unsigned P = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic mode;
    logic en_pulse;
    logic btn_level;
    logic mode_s;

    always #5 clk = ~clk;

    enable_pulse_gen #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .PRESCALE        (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .mode      (mode),
        .en_pulse  (en_pulse),
        .btn_level (btn_level),
        .mode_s    (mode_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: inputs delayed S edges, debounced level flips after
    // D+1 consecutive disagreeing samples, prescaler ticks every P-th
    // consecutive auto sample, and no strobe directly after a strobe.
    bit          bq[$];
    bit          mq[$];
    bit          m_level;
    bit          m_last_en;
    bit          m_en;
    bit          m_ms;
    int unsigned m_drun;
    int unsigned m_prun;

    task automatic model_reset();
        bq.delete();
        mq.delete();
        for (int i = 0; i < S; i++) begin
            bq.push_back(1'b0);
            mq.push_back(1'b0);
        end
        m_level   = 1'b0;
        m_last_en = 1'b0;
        m_en      = 1'b0;
        m_ms      = 1'b0;
        m_drun    = 0;
        m_prun    = 0;
    endtask

    task automatic model_edge();
        bit bs;
        bit ms;
        bit press;
        bit tick;
        bs = bq.pop_front();
        ms = mq.pop_front();
        bq.push_back(btn_raw);
        mq.push_back(mode);
        press = 1'b0;
        if (bs != m_level) begin
            m_drun++;
            if (m_drun == D + 1) begin
                m_level = bs;
                press   = bs;
                m_drun  = 0;
            end
        end else begin
            m_drun = 0;
        end
        if (ms) begin
            m_prun++;
            tick = ((m_prun % P) == 0);
        end else begin
            m_prun = 0;
            tick   = 1'b0;
        end
        m_en      = m_last_en ? 1'b0 : (ms ? tick : press);
        m_last_en = m_en;
        m_ms      = mq[0];
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_bit("en_pulse", en_pulse, m_en);
        check_bit("btn_level", btn_level, m_level);
        check_bit("mode_s", mode_s, m_ms);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_count(input int n, output int strobes, output int first_at);
        strobes  = 0;
        first_at = -1;
        for (int k = 0; k < n; k++) begin
            step();
            if (en_pulse === 1'b1) begin
                strobes++;
                if (first_at < 0) first_at = k;
            end
        end
    endtask

    initial begin
        int cnt;
        int first;
        int fall;
        bit bounce [5];
        bit target;
        int run_left;

        // Reset state
        rst = 1'b0; btn_raw = 1'b0; mode = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();

        // Clean press held for 50+ cycles
        btn_raw = 1'b1;
        run_count(57, cnt, first);
        check_int("clean_first_edge", first, 6);
        check_int("clean_strobes", cnt, 1);

        // Release: level falls after edge 6, no strobe
        btn_raw = 1'b0;
        fall = -1; cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (en_pulse === 1'b1) cnt++;
            if (btn_level === 1'b0 && fall < 0) fall = k;
        end
        check_int("release_fall_edge", fall, 6);
        check_int("release_strobes", cnt, 0);

        // Bounce then stable rise
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            btn_raw = bounce[i];
            step();
            if (en_pulse === 1'b1) cnt++;
        end
        check_int("bounce_early_strobes", cnt, 0);
        btn_raw = 1'b1;
        run_count(20, cnt, first);
        check_int("bounce_first_edge", first, 6);
        check_int("bounce_strobes", cnt, 1);
        btn_raw = 1'b0;
        repeat (12) step();

        // Auto mode
        mode = 1'b1;
        run_count(22, cnt, first);
        check_int("auto_first_edge", first, 6);
        check_int("auto_strobes", cnt, 4);
        btn_raw = 1'b1;
        run_count(20, cnt, first);
        check_int("auto_press_strobes", cnt, 4);
        btn_raw = 1'b0;
        repeat (12) step();

        // Mode switch 1 -> 0 while pcnt = 3
        mode = 1'b0;
        repeat (5) step();
        mode = 1'b1;
        repeat (3) step();
        mode = 1'b0;
        run_count(15, cnt, first);
        check_int("modesw_strobes", cnt, 0);
        btn_raw = 1'b1;
        run_count(20, cnt, first);
        check_int("modesw_press_first", first, 6);
        check_int("modesw_press_strobes", cnt, 1);
        btn_raw = 1'b0;
        repeat (12) step();

        // Reset while in WAIT_HIGH with dcnt = 2
        btn_raw = 1'b1;
        repeat (5) step();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (3) step();
        rst = 1'b1;
        run_count(20, cnt, first);
        check_int("rst_press_first", first, 6);
        check_int("rst_press_strobes", cnt, 1);
        btn_raw = 1'b0;
        repeat (12) step();

        // Randomized traffic against the model
        run_left = 0;
        target   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                target   = $urandom_range(0, 1);
                run_left = $urandom_range(1, 15);
            end
            run_left--;
            btn_raw = ($urandom_range(0, 9) == 0) ? ~target : target;
            if ($urandom_range(0, 79) == 0) mode = ~mode;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_outputs();
                repeat (2) step();
                rst = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_enable_pulse_gen
